ddr4_v2_2_24_tg_pattern_gen_data_bram_seq: RTL and testbench

- Sequencer stage directly upstream of the TG BRAM data-pattern ROM.
- Generates `bram_ptr` over a configured entry window, with wrap-around.
- Registers the ROM's combinational `bram_out` into a valid/ready output beat for the TG write-data path.
- Counts delivered beats and pulses `done` when the programmed count has been delivered.

---
 rtl/ddr4_v2_2_24_tg_pattern_gen_pkg.sv | 28 ++
 rtl/ddr4_v2_2_24_tg_pattern_gen_data_bram_seq.sv | 138 +++++++++++++
 tb/tb_ddr4_v2_2_24_tg_pattern_gen_data_bram_seq.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr4_v2_2_24_tg_pattern_gen_pkg.sv
// Shared state type and pointer helper for the TG BRAM pattern sequencer.
package ddr4_v2_2_24_tg_pattern_gen_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } tg_bram_seq_state_e;

   localparam int unsigned PTR_FN_W = 32;

   // Window walk: end returns to start, otherwise increment modulo 2^pw.
   function automatic logic [PTR_FN_W-1:0] bram_ptr_next(
      input logic [PTR_FN_W-1:0] ptr,
      input logic [PTR_FN_W-1:0] start_p,
      input logic [PTR_FN_W-1:0] end_p,
      input int unsigned         pw
   );
      logic [PTR_FN_W-1:0] mask;
      mask = (pw >= PTR_FN_W) ? '1
                              : ((PTR_FN_W'(1) << pw) - PTR_FN_W'(1));
      if (ptr == end_p)
         return start_p;
      return (ptr + PTR_FN_W'(1)) & mask;
   endfunction

endpackage

// File: rtl/ddr4_v2_2_24_tg_pattern_gen_data_bram_seq.sv
// Walks the pattern ROM pointer over a window and presents registered
// ROM beats on a valid/ready interface, counting accepted beats.
module ddr4_v2_2_24_tg_pattern_gen_data_bram_seq
   import ddr4_v2_2_24_tg_pattern_gen_pkg::*;
#(
   parameter int TCQ                             = 100,
   parameter int NUM_DQ_PINS                     = 36,
   parameter int nCK_PER_CLK                     = 4,
   parameter int NUM_PORT                        = 1,
   parameter int TG_PATTERN_LOG2_NUM_BRAM_ENTRY  = 9,
   parameter int BEAT_CNT_WIDTH                  = 32,
   localparam int PW = TG_PATTERN_LOG2_NUM_BRAM_ENTRY,
   localparam int DW = NUM_DQ_PINS*2*nCK_PER_CLK*NUM_PORT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [PW-1:0]             cfg_start_ptr,
   input  logic [PW-1:0]             cfg_end_ptr,
   input  logic [BEAT_CNT_WIDTH-1:0] cfg_num_beats,
   input  logic                      start,
   input  logic                      stop,
   output logic [PW-1:0]             bram_ptr,
   input  logic [DW-1:0]             bram_out,
   output logic [DW-1:0]             data_out,
   output logic                      data_valid,
   input  logic                      data_ready,
   output logic                      busy,
   output logic                      done
);

   if (TCQ < 0) begin : g_bad_tcq
      $error("TCQ must be non-negative");
   end

   tg_bram_seq_state_e        state_q, state_d;
   logic [PW-1:0]             ptr_q, ptr_d;
   logic [DW-1:0]             data_q, data_d;
   logic                      valid_q, valid_d;
   logic [BEAT_CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [PW-1:0]             cfg_start_q, cfg_start_d;
   logic [PW-1:0]             cfg_end_q, cfg_end_d;
   logic [BEAT_CNT_WIDTH-1:0] cfg_beats_q, cfg_beats_d;

   logic [PW-1:0]             ptr_nxt;
   logic [BEAT_CNT_WIDTH-1:0] cnt_inc;
   logic                      hs;
   logic                      last_beat;

   assign ptr_nxt = PW'(bram_ptr_next(PTR_FN_W'(ptr_q),
                                      PTR_FN_W'(cfg_start_q),
                                      PTR_FN_W'(cfg_end_q),
                                      PW));
   assign cnt_inc   = cnt_q + BEAT_CNT_WIDTH'(1);
   assign hs        = valid_q & data_ready;
   assign last_beat = (cfg_beats_q != '0) && (cnt_inc == cfg_beats_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         cnt_q       <= '0;
         cfg_start_q <= '0;
         cfg_end_q   <= '0;
         cfg_beats_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         cnt_q       <= cnt_d;
         cfg_start_q <= cfg_start_d;
         cfg_end_q   <= cfg_end_d;
         cfg_beats_q <= cfg_beats_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      data_d      = data_q;
      valid_d     = valid_q;
      cnt_d       = cnt_q;
      cfg_start_d = cfg_start_q;
      cfg_end_d   = cfg_end_q;
      cfg_beats_d = cfg_beats_q;

      // Abort beats restart; restart beats any pending handshake.
      if (stop && (state_q != IDLE)) begin
         state_d = IDLE;
         valid_d = 1'b0;
      end else if (start) begin
         cfg_start_d = cfg_start_ptr;
         cfg_end_d   = cfg_end_ptr;
         cfg_beats_d = cfg_num_beats;
         ptr_d       = cfg_start_ptr;
         cnt_d       = '0;
         valid_d     = 1'b0;
         state_d     = PRIME;
      end else begin
         unique case (state_q)
            PRIME: begin
               data_d  = bram_out;
               valid_d = 1'b1;
               ptr_d   = ptr_nxt;
               state_d = RUN;
            end
            RUN: begin
               if (hs) begin
                  if (last_beat) begin
                     cnt_d   = cnt_inc;
                     valid_d = 1'b0;
                     state_d = DONE;
                  end else begin
                     cnt_d  = (cnt_q == '1) ? cnt_q : cnt_inc;
                     data_d = bram_out;
                     ptr_d  = ptr_nxt;
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   assign bram_ptr   = ptr_q;
   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);

endmodule

// File: tb/tb_ddr4_v2_2_24_tg_pattern_gen_data_bram_seq.sv
// Scoreboard bench for the TG BRAM pattern sequencer with a small ROM model.
module tb_ddr4_v2_2_24_tg_pattern_gen_data_bram_seq;

   localparam int PW = 9;
   localparam int DW = 288;
   localparam int CW = 32;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [PW-1:0] p;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [PW-1:0] cfg_start_ptr = '0;
   logic [PW-1:0] cfg_end_ptr = '0;
   logic [CW-1:0] cfg_num_beats = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [PW-1:0] bram_ptr;
   logic [DW-1:0] bram_out;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          data_ready = 1'b0;
   logic          busy;
   logic          done;

   int   errors = 0;
   int   checks = 0;
   int   done_cnt = 0;
   bit   sb_en = 1'b1;
   exp_t q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   always_comb begin
      case (bram_ptr)
         9'd0:    bram_out = DW'(12'h123);
         9'd1:    bram_out = DW'(12'h456);
         9'd2:    bram_out = DW'(12'h789);
         9'd3:    bram_out = DW'(12'h0AB);
         default: bram_out = '0;
      endcase
   end

   ddr4_v2_2_24_tg_pattern_gen_data_bram_seq dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_start_ptr (cfg_start_ptr),
      .cfg_end_ptr   (cfg_end_ptr),
      .cfg_num_beats (cfg_num_beats),
      .start         (start),
      .stop          (stop),
      .bram_ptr      (bram_ptr),
      .bram_out      (bram_out),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .data_ready    (data_ready),
      .busy          (busy),
      .done          (done)
   );

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [11:0] d, input logic [PW-1:0] p);
      exp_t e;
      e.d = DW'(d);
      e.p = p;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [PW-1:0] s, input logic [PW-1:0] e,
                              input logic [CW-1:0] n);
      cfg_start_ptr = s;
      cfg_end_ptr   = e;
      cfg_num_beats = n;
      start = 1'b1;
      tick();
      start = 1'b0;
      cfg_start_ptr = '0;
      cfg_end_ptr   = '0;
      cfg_num_beats = '0;
   endtask

   task automatic wait_done(input string name, input int limit);
      int n;
      n = 0;
      while (!done && n < limit) begin
         tick();
         n++;
      end
      chk({name, "_done_seen"}, DW'(done), DW'(1));
      tick();
      chk({name, "_idle_after_done"}, DW'(busy), DW'(0));
      chk({name, "_queue_empty"}, DW'(q.size()), DW'(0));
   endtask

   // Accepted beats are those handshaken with no restart/abort that cycle.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (rst_n && sb_en && data_valid && data_ready && !start && !stop) begin
         if (q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_beat: got %0h expected none", data_out);
         end else begin
            mon_e = q.pop_front();
            chk("beat_data", data_out, mon_e.d);
            chk("beat_ptr", DW'(bram_ptr), DW'(mon_e.p));
         end
      end
   end

   initial begin
      int dc;
      #12;
      chk("rst_valid", DW'(data_valid), DW'(0));
      chk("rst_busy", DW'(busy), DW'(0));
      chk("rst_done", DW'(done), DW'(0));
      chk("rst_ptr", DW'(bram_ptr), DW'(0));
      chk("rst_data", data_out, DW'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Basic: exact latency and done timing
      data_ready = 1'b1;
      push(12'h123, 9'd1); push(12'h456, 9'd2);
      push(12'h789, 9'd3); push(12'h0AB, 9'd0);
      pulse_start(9'd0, 9'd3, 32'd4);
      chk("basic_busy_prime", DW'(busy), DW'(1));
      chk("basic_valid_prime", DW'(data_valid), DW'(0));
      tick();
      chk("basic_first_valid", DW'(data_valid), DW'(1));
      chk("basic_first_data", data_out, DW'(12'h123));
      repeat (4) tick();
      chk("basic_done_T6", DW'(done), DW'(1));
      tick();
      chk("basic_done_1cyc", DW'(done), DW'(0));
      chk("basic_busy_T7", DW'(busy), DW'(0));
      chk("basic_queue_empty", DW'(q.size()), DW'(0));

      // Wrap within a 2-entry window
      push(12'h789, 9'd3); push(12'h0AB, 9'd2); push(12'h789, 9'd3);
      push(12'h0AB, 9'd2); push(12'h789, 9'd3);
      pulse_start(9'd2, 9'd3, 32'd5);
      wait_done("wrap", 40);

      // Backpressure on the second beat
      push(12'h123, 9'd1); push(12'h456, 9'd2);
      push(12'h789, 9'd3); push(12'h0AB, 9'd0);
      pulse_start(9'd0, 9'd3, 32'd4);
      tick();
      tick();
      data_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold_valid", DW'(data_valid), DW'(1));
         chk("bp_hold_data", data_out, DW'(12'h456));
         tick();
      end
      data_ready = 1'b1;
      wait_done("bp", 40);

      // Restart mid-run drops the pending beat and recounts
      pulse_start(9'd0, 9'd3, 32'd8);
      tick();
      cfg_start_ptr = 9'd1;
      cfg_end_ptr   = 9'd3;
      cfg_num_beats = 32'd3;
      start = 1'b1;
      push(12'h456, 9'd2); push(12'h789, 9'd3); push(12'h0AB, 9'd1);
      tick();
      start = 1'b0;
      chk("restart_valid_gap", DW'(data_valid), DW'(0));
      tick();
      chk("restart_first_data", data_out, DW'(12'h456));
      wait_done("restart", 40);

      // Stop mid-run: idle next cycle, no done
      dc = done_cnt;
      push(12'h123, 9'd1); push(12'h456, 9'd2);
      pulse_start(9'd0, 9'd3, 32'd8);
      repeat (3) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_busy", DW'(busy), DW'(0));
      chk("stop_valid", DW'(data_valid), DW'(0));
      repeat (5) tick();
      chk("stop_no_done", DW'(done_cnt), DW'(dc));
      chk("stop_queue_empty", DW'(q.size()), DW'(0));

      // Asynchronous reset during RUN
      data_ready = 1'b0;
      pulse_start(9'd1, 9'd3, 32'd0);
      repeat (2) tick();
      chk("arst_pre_valid", DW'(data_valid), DW'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", DW'(data_valid), DW'(0));
      chk("arst_busy", DW'(busy), DW'(0));
      chk("arst_ptr", DW'(bram_ptr), DW'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Window wrapping through the top of the address space
      data_ready = 1'b1;
      push(12'h000, 9'd0); push(12'h123, 9'd511); push(12'h000, 9'd0);
      pulse_start(9'd511, 9'd0, 32'd3);
      chk("edge_ptr_start", DW'(bram_ptr), DW'(511));
      wait_done("edge", 40);

      // Endless run
      dc = done_cnt;
      sb_en = 1'b0;
      pulse_start(9'd0, 9'd3, 32'd0);
      repeat (1000) tick();
      chk("forever_no_done", DW'(done_cnt), DW'(dc));
      chk("forever_busy", DW'(busy), DW'(1));
      chk("forever_valid", DW'(data_valid), DW'(1));
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("forever_stop_idle", DW'(busy), DW'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
